// File: rtl/bhg_i2s_audio_tx.sv
// I2S transmitter: serialises signed stereo PCM words as BCLK/LRCLK/SDATA with a
// one-deep pending buffer and a one-clk sample_req pulse at every frame load.
module bhg_i2s_audio_tx #(
    parameter int IN_BITS   = 12,
    parameter int SLOT_BITS = 16,
    parameter int BCLK_DIV  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               in_valid,
    input  logic [IN_BITS-1:0] s_l,
    input  logic [IN_BITS-1:0] s_r,
    output logic               sample_req,
    input  logic               clr_status,
    output logic               overrun,
    output logic               underrun,
    output logic               i2s_bclk,
    output logic               i2s_lrclk,
    output logic               i2s_sdata
);

    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int PAD_BITS   = SLOT_BITS - IN_BITS;
    localparam int DIV_W      = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
    localparam int BIT_W      = $clog2(FRAME_BITS);

    logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
    logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
    logic [FRAME_BITS-1:0] frame_q, frame_d;
    logic [IN_BITS-1:0]    pend_l_q, pend_l_d;
    logic [IN_BITS-1:0]    pend_r_q, pend_r_d;
    logic                  fresh_q, fresh_d;
    logic                  overrun_q, overrun_d;
    logic                  underrun_q, underrun_d;
    logic                  sample_req_q, sample_req_d;
    logic                  bclk_q, bclk_d;
    logic                  lrclk_q, lrclk_d;
    logic                  sdata_q, sdata_d;

    logic                  load;
    logic                  div_wrap;
    logic [BIT_W-1:0]      bit_idx;
    logic [SLOT_BITS-1:0]  slot_l;
    logic [SLOT_BITS-1:0]  slot_r;

    always_comb begin
        load     = en && (div_cnt_q == '0) && (bit_cnt_q == '0);
        div_wrap = (div_cnt_q == DIV_W'(BCLK_DIV - 1));
        // Period k (k >= 1) carries frame bit FRAME_BITS-k: the one-bit I2S delay.
        bit_idx  = BIT_W'(FRAME_BITS - 1) - (bit_cnt_q - BIT_W'(1));
        slot_l   = SLOT_BITS'(pend_l_q) << PAD_BITS;
        slot_r   = SLOT_BITS'(pend_r_q) << PAD_BITS;

        div_cnt_d    = div_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        frame_d      = frame_q;
        bclk_d       = bclk_q;
        lrclk_d      = lrclk_q;
        sdata_d      = sdata_q;
        sample_req_d = load;

        if (!en) begin
            div_cnt_d = '0;
            bit_cnt_d = '0;
            frame_d   = '0;
            bclk_d    = 1'b0;
            lrclk_d   = 1'b0;
            sdata_d   = 1'b0;
        end else begin
            div_cnt_d = div_wrap ? '0 : div_cnt_q + DIV_W'(1);
            if (div_wrap) begin
                bit_cnt_d = (bit_cnt_q == BIT_W'(FRAME_BITS - 1)) ? '0 : bit_cnt_q + BIT_W'(1);
            end
            bclk_d  = (div_cnt_q >= DIV_W'(BCLK_DIV / 2));
            lrclk_d = (bit_cnt_q >= BIT_W'(SLOT_BITS));
            // Period 0 still shows the previous frame's right LSB, taken before the reload.
            if (div_cnt_q == '0) begin
                sdata_d = (bit_cnt_q == '0) ? frame_q[0] : frame_q[bit_idx];
            end
            if (load) begin
                frame_d = {slot_l, slot_r};
            end
        end

        pend_l_d   = pend_l_q;
        pend_r_d   = pend_r_q;
        fresh_d    = fresh_q;
        overrun_d  = (overrun_q && !clr_status) || (in_valid && fresh_q && !load);
        underrun_d = (underrun_q && !clr_status) || (load && !fresh_q);
        if (in_valid) begin
            pend_l_d = s_l;
            pend_r_d = s_r;
            fresh_d  = 1'b1;
        end else if (load) begin
            fresh_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt_q    <= '0;
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            pend_l_q     <= '0;
            pend_r_q     <= '0;
            fresh_q      <= 1'b0;
            overrun_q    <= 1'b0;
            underrun_q   <= 1'b0;
            sample_req_q <= 1'b0;
            bclk_q       <= 1'b0;
            lrclk_q      <= 1'b0;
            sdata_q      <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_q      <= frame_d;
            pend_l_q     <= pend_l_d;
            pend_r_q     <= pend_r_d;
            fresh_q      <= fresh_d;
            overrun_q    <= overrun_d;
            underrun_q   <= underrun_d;
            sample_req_q <= sample_req_d;
            bclk_q       <= bclk_d;
            lrclk_q      <= lrclk_d;
            sdata_q      <= sdata_d;
        end
    end

    assign sample_req = sample_req_q;
    assign overrun    = overrun_q;
    assign underrun   = underrun_q;
    assign i2s_bclk   = bclk_q;
    assign i2s_lrclk  = lrclk_q;
    assign i2s_sdata  = sdata_q;

endmodule

// File: tb/tb_bhg_i2s_audio_tx.sv
// Bench for bhg_i2s_audio_tx: frame-level reference model feeding an expected-frame
// queue, an I2S receiver that decodes SDATA, and per-cycle flag/clock checks.
module tb_bhg_i2s_audio_tx;

    localparam int IN    = 12;
    localparam int SLOT  = 16;
    localparam int DIV   = 8;
    localparam int FRAME = 2 * SLOT * DIV;

    logic          clk = 1'b0;
    logic          rst, en, in_valid, clr_status;
    logic [IN-1:0] s_l, s_r;
    logic          sample_req, overrun, underrun, i2s_bclk, i2s_lrclk, i2s_sdata;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 0;

    // reference model state (updated on posedge, read on negedge)
    int            m_cnt;
    logic [IN-1:0] m_pl, m_pr;
    bit            m_fresh, m_ov, m_un, m_req, m_bclk, m_lr, m_quiet;
    bit            mon_resync;
    logic [2*SLOT-1:0] exp_q[$];

    bhg_i2s_audio_tx #(.IN_BITS(IN), .SLOT_BITS(SLOT), .BCLK_DIV(DIV)) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .in_valid   (in_valid),
        .s_l        (s_l),
        .s_r        (s_r),
        .sample_req (sample_req),
        .clr_status (clr_status),
        .overrun    (overrun),
        .underrun   (underrun),
        .i2s_bclk   (i2s_bclk),
        .i2s_lrclk  (i2s_lrclk),
        .i2s_sdata  (i2s_sdata)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #800000;
        $display("FAIL timeout: simulation did not finish, tests %0d", n_tests);
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: frames every FRAME enabled clocks from the enabling edge
    always @(posedge clk) begin : model
        bit load, ov_set, un_set;
        if (rst) begin
            m_cnt = 0; m_pl = '0; m_pr = '0; m_fresh = 0; m_ov = 0; m_un = 0;
            m_req = 0; m_bclk = 0; m_lr = 0; m_quiet = 1;
            exp_q.delete();
            mon_resync = 1;
        end else begin
            load   = en && (m_cnt % FRAME == 0);
            ov_set = in_valid && m_fresh && !load;
            un_set = load && !m_fresh;
            if (load) exp_q.push_back({m_pl, {(SLOT-IN){1'b0}}, m_pr, {(SLOT-IN){1'b0}}});
            m_req = load;
            if (en) begin
                m_bclk  = (m_cnt % DIV) >= DIV / 2;
                m_lr    = (m_cnt % FRAME) >= FRAME / 2;
                m_quiet = 0;
                m_cnt++;
            end else begin
                m_bclk = 0; m_lr = 0; m_quiet = 1; m_cnt = 0;
                exp_q.delete();
                mon_resync = 1;
            end
            m_ov = ov_set || (m_ov && !clr_status);
            m_un = un_set || (m_un && !clr_status);
            if (in_valid) begin
                m_pl = s_l; m_pr = s_r; m_fresh = 1;
            end else if (load) begin
                m_fresh = 0;
            end
        end
    end

    // per-cycle checks of pulses, flags and clocks
    always @(negedge clk) begin
        if (chk_on) begin
            check("sample_req", sample_req, m_req);
            check("overrun", overrun, m_ov);
            check("underrun", underrun, m_un);
            check("bclk", i2s_bclk, m_bclk);
            check("lrclk", i2s_lrclk, m_lr);
            if (m_quiet) check("sdata_idle", i2s_sdata, 1'b0);
        end
    end

    // I2S receiver / scoreboard: samples SDATA on each BCLK rise
    always @(negedge clk) begin : monitor
        static bit prev_b = 0, prev_lr = 0, first = 1, collecting = 0;
        static int nbits = 0;
        static logic [2*SLOT-1:0] rx = '0;
        logic [2*SLOT-1:0] exp;
        if (mon_resync) begin
            mon_resync = 0; first = 1; collecting = 0; nbits = 0; prev_lr = 0;
        end else if (chk_on && !prev_b && i2s_bclk) begin
            if (!i2s_lrclk && (prev_lr || first)) begin
                if (first) begin
                    check("sdata_period0_start", i2s_sdata, 1'b0);
                end else if (collecting) begin
                    rx = {rx[2*SLOT-2:0], i2s_sdata};
                    n_tests++;
                    if (nbits != 2*SLOT-1) begin
                        n_fail++;
                        $display("FAIL frame_len: got %0d bits expected %0d", nbits + 1, 2*SLOT);
                    end else if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL frame: got %h expected none queued", rx);
                    end else begin
                        exp = exp_q.pop_front();
                        if (rx !== exp) begin
                            n_fail++;
                            $display("FAIL frame: got %h expected %h at %0t", rx, exp, $time);
                        end
                    end
                end
                first = 0; collecting = 1; nbits = 0;
            end else if (collecting) begin
                rx = {rx[2*SLOT-2:0], i2s_sdata};
                nbits++;
            end
            prev_lr = i2s_lrclk;
        end
        prev_b = i2s_bclk;
    end

    // driver tasks: inputs change 1 time unit after the active edge
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [IN-1:0] l, input logic [IN-1:0] r);
        in_valid = 1; s_l = l; s_r = r;
        tick(1);
        in_valid = 0;
    endtask

    task automatic pulse_clr();
        clr_status = 1;
        tick(1);
        clr_status = 0;
    endtask

    // returns when the next edge has the given clk offset within the frame
    task automatic wait_phase(input int ph);
        int guard = 0;
        while ((m_cnt % FRAME) != ph && guard < 2 * FRAME) begin
            tick(1);
            guard++;
        end
        n_tests++;
        if ((m_cnt % FRAME) != ph) begin
            n_fail++;
            $display("FAIL wait_phase: got phase %0d expected %0d", m_cnt % FRAME, ph);
        end
    endtask

    task automatic check_all_low(input string tag);
        check({tag, "_sample_req"}, sample_req, 1'b0);
        check({tag, "_overrun"}, overrun, 1'b0);
        check({tag, "_underrun"}, underrun, 1'b0);
        check({tag, "_bclk"}, i2s_bclk, 1'b0);
        check({tag, "_lrclk"}, i2s_lrclk, 1'b0);
        check({tag, "_sdata"}, i2s_sdata, 1'b0);
    endtask

    initial begin
        rst = 1; en = 0; in_valid = 0; clr_status = 0; s_l = '0; s_r = '0;
        tick(1);
        chk_on = 1;
        tick(3);
        check_all_low("reset");
        rst = 0;
        en  = 1;

        // known sample before frame 2: left 8000, right 7FF0
        tick(40);
        send(12'h800, 12'h7FF);
        pulse_clr();

        // overrun: two samples within one frame, second one is sent
        wait_phase(10);
        send(12'h001, 12'h005);
        tick(20);
        send(12'h002, 12'h006);
        tick(1);
        check("overrun_set", overrun, 1'b1);
        pulse_clr();
        check("overrun_clr", overrun, 1'b0);

        // underrun: frame with no fresh sample, clear asserted on the same edge
        wait_phase(1);
        wait_phase(0);
        clr_status = 1;
        tick(1);
        clr_status = 0;
        check("underrun_set_beats_clr", underrun, 1'b1);
        pulse_clr();

        // in_valid coincident with frame load
        wait_phase(0);
        send(12'h3A5, 12'hC5A);
        check("simul_underrun", underrun, 1'b1);
        check("simul_overrun", overrun, 1'b0);
        pulse_clr();

        // randomized mixer-like traffic
        for (int f = 0; f < 10; f++) begin
            wait_phase($urandom_range(1, 250));
            if ($urandom_range(0, 4) != 0) send(12'($urandom), 12'($urandom));
            if ($urandom_range(0, 3) == 0) begin
                tick($urandom_range(1, 3));
                send(12'($urandom), 12'($urandom));
            end
            if ($urandom_range(0, 2) == 0) pulse_clr();
        end

        // reset at bit 20 of a frame
        send(12'h123, 12'h456);
        wait_phase(20 * DIV);
        rst = 1;
        tick(1);
        check_all_low("rst_mid");
        rst = 0;
        send(12'h7F0, 12'h80F);
        for (int f = 0; f < 3; f++) begin
            wait_phase($urandom_range(1, 200));
            send(12'($urandom), 12'($urandom));
        end

        // enable dropped mid-frame, restart aligned at bit 0
        wait_phase(100);
        en = 0;
        tick(30);
        check("en_low_bclk", i2s_bclk, 1'b0);
        check("en_low_lrclk", i2s_lrclk, 1'b0);
        check("en_low_sdata", i2s_sdata, 1'b0);
        send(12'h5A5, 12'hA5A);
        en = 1;
        tick(1);
        check("en_restart_req", sample_req, 1'b1);
        for (int f = 0; f < 3; f++) begin
            wait_phase($urandom_range(1, 200));
            send(12'($urandom), 12'($urandom));
        end

        tick(2 * FRAME);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
